uart_rx_frontend: RTL and testbench

- Conditions the raw Bluetooth-module serial pin and drives the cleaned line into the NIOS system's bt_uart_RXD input, so it sits directly upstream of that UART.
- Also decodes the same line as 8N1 frames into a small FIFO, with error and break flags, for hardware-side monitoring (activity LEDs, debug capture) without loading the CPU.

---
 rtl/uart_rx_frontend.sv | 151 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: conditions the BT serial pin for bt_uart_RXD and decodes 8N1 bytes into a small FIFO
module uart_rx_frontend #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       rxd_pin,
  output logic       rxd_clean,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       line_break,
  output logic [7:0] err_count
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int RW  = $clog2(FILTER_LEN + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF     = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST     = CW'(CPB - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, clean_q, clean_d, prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, err_count_q, err_count_d;
  logic        frame_err_q, frame_err_d, overrun_q, overrun_d, line_break_q, line_break_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] fill_q, fill_d;
  logic        pop, full, push, wr;
  assign rx_valid   = fill_q != '0;
  assign full       = fill_q == FULL;
  assign pop        = rx_valid && rx_ready;
  assign rx_data    = rx_valid ? mem_q[rp_q] : 8'h00;
  assign rxd_clean  = clean_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign line_break = line_break_q;
  assign err_count  = err_count_q;
  always_comb begin
    sync1_d = rxd_pin;
    sync2_d = sync1_q;
    clean_d = clean_q;
    run_d   = '0;
    // a disagreeing sample extends the run; an agreeing one restarts it
    if (sync2_q != clean_q) begin
      run_d   = run_q == RUN_LAST ? '0 : run_q + 1'b1;
      clean_d = run_q == RUN_LAST ? sync2_q : clean_q;
    end
    prev_d       = clean_q;
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    line_break_d = line_break_q;
    err_count_d  = err_count_q;
    push         = 1'b0;
    case (state_q)
      IDLE: if (prev_q && !clean_q) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == HALF) begin
        state_d = clean_q ? IDLE : DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end
      DATA: if (cnt_q == LAST) begin
        shift_d = {clean_q, shift_q[7:1]};
        cnt_d   = '0;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt_q == LAST) begin
        if (clean_q) begin
          push      = 1'b1;
          overrun_d = full && !pop;
          state_d   = IDLE;
        end else begin
          frame_err_d  = 1'b1;
          err_count_d  = err_count_q + 8'(err_count_q != 8'hFF);
          line_break_d = shift_q == 8'h00;
          state_d      = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (clean_q) begin
        line_break_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a full FIFO still accepts a byte when the head leaves on the same cycle
    wr    = push && (!full || pop);
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = shift_q;
    wp_d   = wp_q + AW'(wr);
    rp_d   = rp_q + AW'(pop);
    fill_d = fill_q + (AW + 1)'(wr) - (AW + 1)'(pop);
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      clean_q      <= 1'b1;
      prev_q       <= 1'b1;
      run_q        <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      line_break_q <= 1'b0;
      err_count_q  <= '0;
      mem_q        <= '{default: '0};
      wp_q         <= '0;
      rp_q         <= '0;
      fill_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      clean_q      <= clean_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      line_break_q <= line_break_d;
      err_count_q  <= err_count_d;
      mem_q        <= mem_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      fill_q       <= fill_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: randomized frames checked every cycle against a frame-level model of filter, FIFO and flags
module tb_uart_rx_frontend;
  localparam int CPB = 16, FL = 3, DEPTH = 8;
  logic       clk_clk = 1'b0, reset_reset = 1'b1, rxd_pin = 1'b1, rx_ready = 1'b0;
  logic       rxd_clean, rx_valid, frame_err, overrun, line_break;
  logic [7:0] rx_data, err_count;
  uart_rx_frontend #(.CLK_HZ(1600), .BAUD(100), .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .rxd_pin(rxd_pin), .rxd_clean(rxd_clean),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .line_break(line_break), .err_count(err_count));
  always #5 clk_clk = ~clk_clk;
  int n_cmp = 0, n_bad = 0;
  byte unsigned mq[$];
  byte unsigned got[$];
  logic hist[$];
  logic m_clean = 1'b1, m_lb = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  int   m_err = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // pin model: the line flips once FL delayed samples all disagree with it
  always @(posedge clk_clk) begin
    if (reset_reset) begin
      hist.delete();
      for (int i = 0; i <= FL; i++) hist.push_back(1'b1);
      m_clean = 1'b1;
      m_lb = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
      m_err = 0;
      mq.delete();
    end else begin
      automatic logic was = m_clean;
      automatic bit all = 1'b1;
      for (int k = 1; k <= FL; k++) if (hist[hist.size() - 1 - k] == m_clean) all = 1'b0;
      if (all) m_clean = ~m_clean;
      if (m_lb && was) m_lb = 1'b0;
      hist.push_back(rxd_pin);
      void'(hist.pop_front());
    end
  end
  always @(negedge clk_clk) begin
    if (reset_reset) begin
      chk("rst_clean", rxd_clean, 1);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_break", line_break, 0);
      chk("rst_err_count", err_count, 0);
    end else begin
      chk("clean", rxd_clean, m_clean);
      chk("valid", rx_valid, mq.size() != 0);
      if (mq.size() != 0) chk("data", rx_data, mq[0]);
      chk("frame_err", frame_err, m_fe);
      chk("overrun", overrun, m_ov);
      chk("break", line_break, m_lb);
      chk("err_count", err_count, m_err);
      if (mq.size() != 0 && rx_ready) begin
        got.push_back(rx_data);
        void'(mq.pop_front());
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask
  task automatic stop_event(byte unsigned d, logic s);
    if (s) begin
      if (mq.size() == DEPTH) m_ov = 1'b1;
      else mq.push_back(d);
    end else begin
      m_fe = 1'b1;
      if (m_err < 255) m_err++;
      if (d == 8'h00) m_lb = 1'b1;
    end
  endtask
  task automatic send_frame(byte unsigned d, logic s);
    logic [9:0] f;
    f = {s, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rxd_pin = f[j];
      tick(j == 9 ? CPB - 1 : CPB);
    end
    stop_event(d, s);
    tick(1);
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask
  task automatic idle(int n);
    rxd_pin = 1'b1;
    tick(n);
  endtask
  initial begin
    tick(3);
    reset_reset = 1'b0;
    idle(10);
    chk("idle_clean", rxd_clean, 1);
    chk("idle_valid", rx_valid, 0);
    chk("idle_err", err_count, 0);
    for (int g = 0; g < 2; g++) begin
      rxd_pin = 1'b0;
      tick(2);
      rxd_pin = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        chk("glitch_clean", rxd_clean, 1);
      end
    end
    rx_ready = 1'b1;
    got.delete();
    send_frame(8'h55, 1'b1);
    idle(6);
    send_frame(8'hA3, 1'b1);
    idle(10);
    chk("two_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("first_55", got[0], 8'h55);
      chk("second_a3", got[1], 8'hA3);
    end
    rx_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      send_frame(byte'(b), 1'b1);
      idle(6);
    end
    got.delete();
    rx_ready = 1'b1;
    tick(20);
    chk("drain_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("drain_order", got[i], i + 1);
    chk("drain_empty", rx_valid, 0);
    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("ferr_count", err_count, 1);
    got.delete();
    send_frame(8'h3C, 1'b1);
    idle(10);
    chk("good_3c", got.size() == 1 ? got[0] : 32'hFFFF, 8'h3C);
    rxd_pin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk(k < 5 ? "lat_hold" : "lat_fall", rxd_clean, k < 5);
    end
    tick(154);
    stop_event(8'h00, 1'b0);
    chk("break_set", line_break, 1);
    chk("break_err", err_count, 2);
    tick(1);
    m_fe = 1'b0;
    tick(160);
    idle(12);
    chk("break_clear", line_break, 0);
    got.delete();
    send_frame(8'h7E, 1'b1);
    idle(6);
    rxd_pin = 1'b0;
    tick(4);
    idle(30);
    chk("after_break_7e", got.size() == 1 ? got[0] : 32'hFFFF, 8'h7E);
    chk("false_start", rx_valid, 0);
    for (int r = 0; r < 24; r++) begin
      rx_ready = 1'($urandom_range(0, 1));
      send_frame(byte'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
      idle($urandom_range(6, 30));
    end
    rx_ready = 1'b1;
    tick(20);
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(6);
    send_frame(8'h22, 1'b1);
    idle(6);
    send_frame(8'h33, 1'b1);
    idle(6);
    chk("queued_valid", rx_valid, 1);
    rxd_pin = 1'b0;
    tick(CPB);
    rxd_pin = 1'b1;
    tick(CPB);
    rxd_pin = 1'b0;
    tick(CPB / 2);
    reset_reset = 1'b1;
    rxd_pin = 1'b1;
    tick(3);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_err", err_count, 0);
    reset_reset = 1'b0;
    idle(10);
    got.delete();
    rx_ready = 1'b1;
    send_frame(8'hC5, 1'b1);
    idle(10);
    chk("post_rst_c5", got.size() == 1 ? got[0] : 32'hFFFF, 8'hC5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
